// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard sequencer for the IF/ID/EX/WB core.
// It tracks the EX and WB slots and produces stall, flush, PC redirect and the WB->EX forward select.
// Optional build macro PIPE_PERF_CNT_EN adds the saturating stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl #(
   parameter int RA_W  = 3,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            imem_ready,
   input  logic            id_valid,
   input  logic [1:0]      id_opcode,
   input  logic [RA_W-1:0] id_rd,
   input  logic [RA_W-1:0] id_rs,
   output logic            stall,
   output logic            flush,
   output logic            pc_load,
   output logic            ex_valid,
   output logic            fwd_rs,
   output logic            wb_we,
   output logic [RA_W-1:0] wb_rd,
   output logic            illegal_op
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam logic [1:0] OP_MOVI = 2'b00;
   localparam logic [1:0] OP_SLL  = 2'b01;
   localparam logic [1:0] OP_ILL  = 2'b10;
   localparam logic [1:0] OP_JMP  = 2'b11;

   typedef enum logic {RUN, REDIRECT} state_t;

   state_t          state_q, state_d;
   logic            ex_v_q, ex_v_d;
   logic [1:0]      ex_op_q, ex_op_d;
   logic [RA_W-1:0] ex_rd_q, ex_rd_d;
   logic [RA_W-1:0] ex_rs_q, ex_rs_d;
   logic            wb_v_q, wb_v_d;
   logic            wb_we_q, wb_we_d;
   logic [RA_W-1:0] wb_rd_q, wb_rd_d;
   logic            illegal_q, illegal_d;
   logic            advance;
   logic            take_id;

   // Control outputs and FSM next state: a jump in EX redirects, then one more squash cycle follows.
   always_comb begin
      state_d = state_q;
      stall   = !imem_ready;
      advance = imem_ready;
      pc_load = 1'b0;
      flush   = 1'b0;
      case (state_q)
         RUN: begin
            pc_load = ex_v_q && (ex_op_q == OP_JMP);
            flush   = pc_load;
            if (advance && pc_load) begin
               state_d = REDIRECT;
            end
         end
         REDIRECT: begin
            flush = 1'b1;
            if (advance) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Slot movement: ID enters EX unless squashed, EX moves to WB; everything holds while stalled.
   always_comb begin
      take_id   = id_valid && !flush;
      ex_v_d    = ex_v_q;
      ex_op_d   = ex_op_q;
      ex_rd_d   = ex_rd_q;
      ex_rs_d   = ex_rs_q;
      wb_v_d    = wb_v_q;
      wb_we_d   = wb_we_q;
      wb_rd_d   = wb_rd_q;
      illegal_d = 1'b0;
      if (advance) begin
         wb_v_d    = ex_v_q;
         wb_we_d   = ex_v_q && ((ex_op_q == OP_MOVI) || (ex_op_q == OP_SLL));
         wb_rd_d   = ex_rd_q;
         ex_v_d    = take_id;
         ex_op_d   = take_id ? id_opcode : OP_MOVI;
         ex_rd_d   = take_id ? id_rd : '0;
         ex_rs_d   = take_id ? id_rs : '0;
         illegal_d = take_id && (id_opcode == OP_ILL);
      end
   end

   // Forwarding only for SLL, and only from a WB slot that actually writes the register SLL reads.
   always_comb begin
      fwd_rs     = ex_v_q && (ex_op_q == OP_SLL) && wb_v_q && wb_we_q && (wb_rd_q == ex_rs_q);
      ex_valid   = ex_v_q;
      wb_we      = wb_we_q;
      wb_rd      = wb_rd_q;
      illegal_op = illegal_q;
   end

   // State registers with synchronous reset; reset also drops any pending redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RUN;
         ex_v_q    <= 1'b0;
         ex_op_q   <= OP_MOVI;
         ex_rd_q   <= '0;
         ex_rs_q   <= '0;
         wb_v_q    <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_rd_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ex_v_q    <= ex_v_d;
         ex_op_q   <= ex_op_d;
         ex_rd_q   <= ex_rd_d;
         ex_rs_q   <= ex_rs_d;
         wb_v_q    <= wb_v_d;
         wb_we_q   <= wb_we_d;
         wb_rd_q   <= wb_rd_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating counters: stalled cycles, and flush cycles that actually squash an ID slot.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && advance && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      stall_cnt = stall_cnt_q;
      flush_cnt = flush_cnt_q;
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table for the pipeline corner cases, then randomized
// traffic compared against a squash-budget model of the pipeline.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       imem_ready;
   logic       id_valid;
   logic [1:0] id_opcode;
   logic [2:0] id_rd;
   logic [2:0] id_rs;
   logic       stall, flush, pc_load, ex_valid, fwd_rs, wb_we, illegal_op;
   logic [2:0] wb_rd;
`ifdef PIPE_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(.RA_W(3), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .imem_ready(imem_ready), .id_valid(id_valid),
      .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs),
      .stall(stall), .flush(flush), .pc_load(pc_load), .ex_valid(ex_valid),
      .fwd_rs(fwd_rs), .wb_we(wb_we), .wb_rd(wb_rd), .illegal_op(illegal_op)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, rdy, idv;
      logic [1:0] op;
      logic [2:0] rd, rs;
      logic       e_stall, e_flush, e_pc, e_exv, e_fwd, e_we;
      logic [2:0] e_rd;
      logic       chk_rd, e_ill;
   } vec_t;

   vec_t vecs[21];

   // Reference model state: instruction records plus the number of ID slots still to be squashed.
   typedef struct { bit v; int op; int rd; int rs; } instr_t;
   instr_t m_ex;
   bit     m_wb_v, m_wb_we;
   int     m_wb_rd;
   int     squash_left;
   bit     m_ill;
   int     m_stall_cnt, m_flush_cnt;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic rdy, input logic idv,
                                input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs);
      reset      = rst;
      imem_ready = rdy;
      id_valid   = idv;
      id_opcode  = op;
      id_rd      = rd;
      id_rs      = rs;
   endtask

   task automatic modelReset();
      m_ex        = '{v: 1'b0, op: 0, rd: 0, rs: 0};
      m_wb_v      = 1'b0;
      m_wb_we     = 1'b0;
      m_wb_rd     = 0;
      squash_left = 0;
      m_ill       = 1'b0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic modelStep();
      bit sq;
      if (reset) begin
         modelReset();
      end else begin
         if (!imem_ready) begin
            if (m_stall_cnt < 65535) m_stall_cnt++;
            m_ill = 1'b0;
         end else begin
            sq = (squash_left > 0);
            if (sq && m_flush_cnt < 65535) m_flush_cnt++;
            m_wb_v  = m_ex.v;
            m_wb_we = m_ex.v && (m_ex.op == 0 || m_ex.op == 1);
            m_wb_rd = m_ex.rd;
            if (sq) squash_left--;
            m_ill = 1'b0;
            if (id_valid && !sq) begin
               m_ex = '{v: 1'b1, op: int'(id_opcode), rd: int'(id_rd), rs: int'(id_rs)};
               if (id_opcode == 2'b11) squash_left = 2;
               if (id_opcode == 2'b10) m_ill = 1'b1;
            end else begin
               m_ex.v = 1'b0;
            end
         end
      end
   endtask

   task automatic checkModel();
      int e_fwd;
      e_fwd = (m_ex.v && m_ex.op == 1 && m_wb_v && m_wb_we && m_wb_rd == m_ex.rs) ? 1 : 0;
      checkOutput("rnd_stall", int'(stall), imem_ready ? 0 : 1);
      checkOutput("rnd_flush", int'(flush), (squash_left > 0) ? 1 : 0);
      checkOutput("rnd_pc_load", int'(pc_load), (squash_left == 2) ? 1 : 0);
      checkOutput("rnd_ex_valid", int'(ex_valid), int'(m_ex.v));
      checkOutput("rnd_fwd_rs", int'(fwd_rs), e_fwd);
      checkOutput("rnd_wb_we", int'(wb_we), int'(m_wb_we));
      if (m_wb_we) checkOutput("rnd_wb_rd", int'(wb_rd), m_wb_rd);
      checkOutput("rnd_illegal_op", int'(illegal_op), int'(m_ill));
`ifdef PIPE_PERF_CNT_EN
      checkOutput("rnd_stall_cnt", int'(stall_cnt), m_stall_cnt);
      checkOutput("rnd_flush_cnt", int'(flush_cnt), m_flush_cnt);
`endif
   endtask

   // Main test: reset, directed vector table, then randomized traffic against the model.
   initial begin
      //            rst  rdy  idv  op     rd  rs  stl flu pc  exv fwd we  erd chk ill
      vecs[0]  = '{1'b0,1'b1,1'b1,2'b00,3'd2,3'd0, 0,0,0,0,0,0, 3'd0,1,0}; // after reset, MOVI r2 in ID
      vecs[1]  = '{1'b0,1'b1,1'b1,2'b01,3'd3,3'd2, 0,0,0,1,0,0, 3'd0,0,0}; // SLL r3,r2 in ID
      vecs[2]  = '{1'b0,1'b1,1'b0,2'b00,3'd0,3'd0, 0,0,0,1,1,1, 3'd2,1,0}; // SLL in EX forwards from MOVI r2
      vecs[3]  = '{1'b0,1'b1,1'b1,2'b11,3'd0,3'd0, 0,0,0,0,0,1, 3'd3,1,0}; // JMP in ID
      vecs[4]  = '{1'b0,1'b1,1'b1,2'b00,3'd5,3'd0, 0,1,1,1,0,0, 3'd0,0,0}; // JMP in EX, wrong path 1
      vecs[5]  = '{1'b0,1'b1,1'b1,2'b01,3'd6,3'd3, 0,1,0,0,0,0, 3'd0,0,0}; // redirect cycle, wrong path 2
      vecs[6]  = '{1'b0,1'b1,1'b1,2'b10,3'd1,3'd1, 0,0,0,0,0,0, 3'd0,0,0}; // back to run, illegal in ID
      vecs[7]  = '{1'b0,1'b1,1'b1,2'b00,3'd4,3'd0, 0,0,0,1,0,0, 3'd0,0,1}; // illegal in EX pulses
      vecs[8]  = '{1'b0,1'b1,1'b0,2'b00,3'd0,3'd0, 0,0,0,1,0,0, 3'd0,0,0}; // illegal in WB, no write
      vecs[9]  = '{1'b0,1'b1,1'b1,2'b11,3'd0,3'd0, 0,0,0,0,0,1, 3'd4,1,0}; // JMP in ID, MOVI r4 writes
      vecs[10] = '{1'b0,1'b0,1'b1,2'b00,3'd7,3'd0, 1,1,1,1,0,0, 3'd0,0,0}; // JMP in EX, stalled 1
      vecs[11] = '{1'b0,1'b0,1'b1,2'b00,3'd7,3'd0, 1,1,1,1,0,0, 3'd0,0,0}; // stalled 2
      vecs[12] = '{1'b0,1'b0,1'b1,2'b00,3'd7,3'd0, 1,1,1,1,0,0, 3'd0,0,0}; // stalled 3
      vecs[13] = '{1'b0,1'b1,1'b1,2'b00,3'd7,3'd0, 0,1,1,1,0,0, 3'd0,0,0}; // release cycle loads PC
      vecs[14] = '{1'b0,1'b1,1'b1,2'b00,3'd7,3'd0, 0,1,0,0,0,0, 3'd0,0,0}; // redirect cycle
      vecs[15] = '{1'b0,1'b1,1'b1,2'b00,3'd2,3'd0, 0,0,0,0,0,0, 3'd0,0,0}; // MOVI r2
      vecs[16] = '{1'b0,1'b1,1'b1,2'b01,3'd3,3'd4, 0,0,0,1,0,0, 3'd0,0,0}; // SLL r3,r4
      vecs[17] = '{1'b0,1'b1,1'b1,2'b11,3'd0,3'd0, 0,0,0,1,0,1, 3'd2,1,0}; // SLL r4 does not forward
      vecs[18] = '{1'b0,1'b1,1'b0,2'b00,3'd0,3'd0, 0,1,1,1,0,1, 3'd3,1,0}; // JMP in EX
      vecs[19] = '{1'b1,1'b1,1'b0,2'b00,3'd0,3'd0, 0,1,0,0,0,0, 3'd0,0,0}; // reset while redirecting
      vecs[20] = '{1'b0,1'b1,1'b0,2'b00,3'd0,3'd0, 0,0,0,0,0,0, 3'd0,1,0}; // clean state after reset

      applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].idv, vecs[i].op, vecs[i].rd, vecs[i].rs);
         #1;
         checkOutput($sformatf("v%0d_stall", i), int'(stall), int'(vecs[i].e_stall));
         checkOutput($sformatf("v%0d_flush", i), int'(flush), int'(vecs[i].e_flush));
         checkOutput($sformatf("v%0d_pc_load", i), int'(pc_load), int'(vecs[i].e_pc));
         checkOutput($sformatf("v%0d_ex_valid", i), int'(ex_valid), int'(vecs[i].e_exv));
         checkOutput($sformatf("v%0d_fwd_rs", i), int'(fwd_rs), int'(vecs[i].e_fwd));
         checkOutput($sformatf("v%0d_wb_we", i), int'(wb_we), int'(vecs[i].e_we));
         if (vecs[i].chk_rd) checkOutput($sformatf("v%0d_wb_rd", i), int'(wb_rd), int'(vecs[i].e_rd));
         checkOutput($sformatf("v%0d_illegal_op", i), int'(illegal_op), int'(vecs[i].e_ill));
`ifdef PIPE_PERF_CNT_EN
         if (i == 20) begin
            checkOutput("v20_stall_cnt", int'(stall_cnt), 0);
            checkOutput("v20_flush_cnt", int'(flush_cnt), 0);
         end
`endif
      end

      // Randomized traffic, starting from a reset so the model and DUT agree.
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0);
      @(posedge clk);
      modelReset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         applyStimulus(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0,
                       2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         #1;
         checkModel();
         @(posedge clk);
         modelStep();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
